seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter: N_BITS, 32, operand and result width.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand request valid.
REQ-005 SHALL have port: in_ready  output  1  divider idle, can accept.
REQ-006 SHALL have port: is_signed  input  1  1 = two's-complement DIV/REM, 0 = unsigned DIVU/REMU.
REQ-007 SHALL have port: dividend  input  N_BITS  numerator.
REQ-008 SHALL have port: divisor  input  N_BITS  denominator.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: quotient  output  N_BITS  quotient, truncated toward zero.
REQ-012 SHALL have port: remainder  output  N_BITS  remainder, sign of dividend.
REQ-013 SHALL have port: div_by_zero  output  1  flag, valid with out_valid.

Function
REQ-014 SHALL implement the FSM states IDLE, CALC, FIX, DONE.
REQ-015 SHALL drive in_ready high only in IDLE.
REQ-016 SHALL accept a request on a rising edge with in_valid and in_ready both high, latching is_signed, dividend and divisor.
REQ-017 SHALL, on acceptance with divisor == 0, go IDLE->DONE with quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-018 SHALL, on signed acceptance with dividend = -2^(N_BITS-1) and divisor = -1, go IDLE->DONE with quotient = dividend, remainder = 0, div_by_zero = 0.
REQ-019 SHALL otherwise go IDLE->CALC, holding operand magnitudes (absolute values when signed) and recording sign of the quotient (XOR of operand signs) and sign of the remainder (dividend sign).
REQ-020 SHALL perform one radix-2 non-restoring step per cycle in CALC for exactly N_BITS cycles, counted by an iteration counter.
REQ-021 SHALL in FIX, for one cycle, add back the divisor if the partial remainder is negative, then negate the quotient and remainder per the recorded signs.
REQ-022 SHALL assert out_valid in DONE only; normal latency is accept edge + N_BITS + 2 edges, and special-case latency is accept edge + 1 edge.
REQ-023 SHALL hold quotient, remainder and div_by_zero stable while out_valid is high and out_ready is low.
REQ-024 SHALL return DONE->IDLE on the edge where out_ready is high; the next request is not accepted before that edge.
REQ-025 SHALL ignore in_valid outside IDLE, with no queuing.
REQ-026 SHALL make all outputs registered, with no combinational path from in_* to out_*.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-CALC, force IDLE and clear out_valid, quotient, remainder, div_by_zero and the iteration counter to 0; in_ready = 1 after reset.
REQ-028 SHALL discard an in-flight operation on reset, producing no result.

Structure
REQ-029 SHALL place the FSM state enumeration, the N_BITS default and the special-case constants (all-ones quotient, most-negative value) in a shared divider package.
REQ-030 SHALL implement one sub-module, div_step: a combinational N_BITS+1-bit add/subtract of the shifted partial remainder, producing the next partial remainder and the quotient bit.

Verification
REQ-031 SHALL cover: unsigned 100 / 7 -> quotient 14, remainder 2, out_valid exactly N_BITS+2 edges after accept.
REQ-032 SHALL cover: signed -100 / 7 -> quotient -14, remainder -2; signed 100 / -7 -> quotient -14, remainder 2.
REQ-033 SHALL cover: divisor 0 with dividend 0x12345678 -> quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero 1, out_valid after 1 edge.
REQ-034 SHALL cover: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned version of the same operands -> quotient 0, remainder 0x80000000.
REQ-035 SHALL cover: out_ready held low for 5 cycles in DONE -> outputs stable, in_ready low, a new in_valid is ignored.
REQ-036 SHALL cover: rst_n pulsed low at iteration 10 of CALC -> out_valid never asserts, in_ready = 1; a following 9 / 3 -> quotient 3, remainder 0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared divider definitions: FSM encoding, default width and the
// special-case result constants used by the sequential divider.
package seq_divider_pkg;

  localparam int DIV_N_BITS = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Wide templates, sliced down to the instance width by the user.
  localparam logic [63:0] DIV_ALL_ONES = '1;

  function automatic logic [63:0] div_most_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 non-restoring iteration: shift the partial remainder,
// then add or subtract the divisor depending on the previous sign.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   p_i,
  input  logic         q_msb_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   p_o,
  output logic         q_o
);

  logic [W:0] shifted;
  logic [W:0] b_ext;

  // Wraparound is harmless: the true result always fits in W+1 bits.
  always_comb begin
    shifted = {p_i[W-1:0], q_msb_i};
    b_ext   = {1'b0, b_i};
    if (p_i[W]) begin
      p_o = shifted + b_ext;
    end else begin
      p_o = shifted - b_ext;
    end
    q_o = ~p_o[W];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed/unsigned divider, one quotient bit per cycle,
// with valid/ready handshakes on both the request and result sides.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N_BITS = DIV_N_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_signed,
  input  logic [N_BITS-1:0] dividend,
  input  logic [N_BITS-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] quotient,
  output logic [N_BITS-1:0] remainder,
  output logic              div_by_zero
);

  localparam int CW = $clog2(N_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);
  localparam logic [63:0] ONES64 = DIV_ALL_ONES;
  localparam logic [63:0] MNEG64 = div_most_neg(N_BITS);
  localparam logic [N_BITS-1:0] ALL_ONES = ONES64[N_BITS-1:0];
  localparam logic [N_BITS-1:0] MOST_NEG = MNEG64[N_BITS-1:0];

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_BITS:0]   p_q, p_d;
  logic [N_BITS-1:0] qr_q, qr_d;
  logic [N_BITS-1:0] b_q, b_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [N_BITS-1:0] quot_q, quot_d;
  logic [N_BITS-1:0] rem_q, rem_d;
  logic              dbz_q, dbz_d;

  logic [N_BITS:0]   step_p;
  logic              step_q;
  logic              dvd_neg, dvs_neg;
  logic [N_BITS-1:0] dvd_mag, dvs_mag;
  logic              by_zero, ovf;
  logic [N_BITS-1:0] fix_rm;

  div_step #(
    .W(N_BITS)
  ) u_step (
    .p_i    (p_q),
    .q_msb_i(qr_q[N_BITS-1]),
    .b_i    (b_q),
    .p_o    (step_p),
    .q_o    (step_q)
  );

  always_comb begin
    dvd_neg = is_signed & dividend[N_BITS-1];
    dvs_neg = is_signed & divisor[N_BITS-1];
    dvd_mag = dvd_neg ? -dividend : dividend;
    dvs_mag = dvs_neg ? -divisor : divisor;
    by_zero = (divisor == '0);
    ovf     = is_signed && (dividend == MOST_NEG)
              && (divisor == ALL_ONES);
    // Final remainder lies in [0, divisor), so N bits suffice.
    fix_rm  = p_q[N_BITS] ? (p_q[N_BITS-1:0] + b_q)
                          : p_q[N_BITS-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    qr_d    = qr_q;
    b_d     = b_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          unique case (1'b1)
            by_zero: begin
              quot_d  = ALL_ONES;
              rem_d   = dividend;
              dbz_d   = 1'b1;
              state_d = S_DONE;
            end
            ovf: begin
              quot_d  = dividend;
              rem_d   = '0;
              dbz_d   = 1'b0;
              state_d = S_DONE;
            end
            default: begin
              p_d     = '0;
              qr_d    = dvd_mag;
              b_d     = dvs_mag;
              negq_d  = dvd_neg ^ dvs_neg;
              negr_d  = dvd_neg;
              cnt_d   = '0;
              state_d = S_CALC;
            end
          endcase
        end
      end
      S_CALC: begin
        p_d   = step_p;
        qr_d  = {qr_q[N_BITS-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quot_d  = negq_q ? -qr_q : qr_q;
        rem_d   = negr_q ? -fix_rm : fix_rm;
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      qr_q    <= '0;
      b_q     <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      qr_q    <= qr_d;
      b_q     <= b_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
